sos_multi_dist: RTL and testbench



---
 rtl/sos_pkg.sv | 22 ++
 rtl/impulse_generator.sv | 40 ++++
 rtl/sos_onset_channel.sv | 129 ++++++++++++
 rtl/sos_multi_dist.sv | 163 ++++++++++++++++
 tb/tb_sos_multi_dist.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sos_pkg.sv
// Shared types and helpers for the speed-of-sound multi-channel ranging engine.
package sos_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIRE,
    WAIT_IMP,
    LISTEN,
    EVAL,
    GAP
  } sos_state_t;

  localparam int unsigned SAMPLE_RATE_HZ = 24_000;

  // |s| with -32768 clamped to 32767 so the result always fits 15 bits.
  function automatic logic [14:0] sat_mag(input logic [15:0] s);
    logic [15:0] n;
    n = s[15] ? (~s + 16'd1) : s;
    return n[15] ? 15'h7fff : n[14:0];
  endfunction

endpackage

// File: rtl/impulse_generator.sv
// Impulse source: on impulse_in drives AMP to the speaker for one audio sample,
// then returns to silence and pulses impulse_out for one cycle.
module impulse_generator #(
  parameter logic signed [15:0] AMP = 16'sd16384
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               step_in,
  input  logic               impulse_in,
  output logic signed [15:0] amp_out,
  output logic               impulse_out
);

  logic               active_q;
  logic signed [15:0] amp_q;
  logic               imp_q;

  // Hold the impulse level until the next audio sample boundary.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      active_q <= 1'b0;
      amp_q    <= '0;
      imp_q    <= 1'b0;
    end else begin
      imp_q <= 1'b0;
      if (impulse_in) begin
        active_q <= 1'b1;
        amp_q    <= AMP;
      end else if (active_q && step_in) begin
        active_q <= 1'b0;
        amp_q    <= '0;
        imp_q    <= 1'b1;
      end
    end
  end

  assign amp_out     = amp_q;
  assign impulse_out = imp_q;

endmodule

// File: rtl/sos_onset_channel.sv
// One microphone channel: onset capture during LISTEN and round-to-round
// agreement tracking in EVAL. With SOS_AVG_EN defined the published delay is
// the rounded mean of the agreeing onsets instead of the last one.
module sos_onset_channel
  import sos_pkg::*;
#(
  parameter int unsigned MAX_DELAY = 512,
  parameter int unsigned CONFIRM   = 3,
  parameter int unsigned TOL       = 1,
  parameter int unsigned DELAY_W   = $clog2(MAX_DELAY + 1)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               session_clr,
  input  logic               round_clr,
  input  logic               listen,
  input  logic               eval,
  input  logic [15:0]        sample,
  input  logic [14:0]        thresh,
  input  logic [DELAY_W-1:0] count,
  output logic               hit,
  output logic               conf_next,
  output logic [DELAY_W-1:0] delay_out,
  output logic               delay_valid,
  output logic               miss
);

  localparam int unsigned MW = $clog2(CONFIRM + 1);

  logic               hit_q;
  logic [DELAY_W-1:0] cur_q;
  logic [DELAY_W-1:0] cand_q;
  logic [MW-1:0]      match_q;
  logic               confirmed_q;
  logic [DELAY_W-1:0] delay_q;
  logic               valid_q;
  logic               miss_q;

  logic [DELAY_W:0]   diff;
  logic               agree;
  logic [MW-1:0]      match_nxt;
  logic               publish;
  logic [DELAY_W-1:0] pub_val;

`ifdef SOS_AVG_EN
  localparam int unsigned AW = DELAY_W + MW;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_nxt;
  logic [AW:0]   rounded;

  if ((CONFIRM & (CONFIRM - 1)) != 0) begin : g_bad_confirm
    $error("CONFIRM must be a power of two when averaging is enabled");
  end
`endif

  // Agreement test against the candidate and the value to publish.
  always_comb begin
    diff      = (cur_q > cand_q) ? ({1'b0, cur_q} - {1'b0, cand_q})
                                 : ({1'b0, cand_q} - {1'b0, cur_q});
    agree     = (match_q != '0) && (diff <= (DELAY_W + 1)'(TOL));
    match_nxt = agree ? (match_q + MW'(1)) : MW'(1);
    publish   = eval && hit_q && (match_nxt == MW'(CONFIRM));
    conf_next = confirmed_q | publish;
`ifdef SOS_AVG_EN
    acc_nxt = agree ? (acc_q + AW'(cur_q)) : AW'(cur_q);
    rounded = {1'b0, acc_nxt} + (AW + 1)'(CONFIRM / 2);
    pub_val = DELAY_W'(rounded >> $clog2(CONFIRM));
`else
    pub_val = cur_q;
`endif
  end

  // Onset capture, match bookkeeping and the published delay.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_q       <= 1'b0;
      cur_q       <= '0;
      cand_q      <= '0;
      match_q     <= '0;
      confirmed_q <= 1'b0;
      delay_q     <= '0;
      valid_q     <= 1'b0;
      miss_q      <= 1'b0;
`ifdef SOS_AVG_EN
      acc_q       <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (session_clr) begin
        miss_q      <= 1'b0;
        confirmed_q <= 1'b0;
        match_q     <= '0;
      end
      if (round_clr) begin
        hit_q <= 1'b0;
        cur_q <= '0;
      end
      if (listen && !hit_q && (sat_mag(sample) > thresh)) begin
        hit_q <= 1'b1;
        cur_q <= count;
      end
      if (eval) begin
        if (hit_q) begin
          if (!agree) cand_q <= cur_q;
`ifdef SOS_AVG_EN
          acc_q <= acc_nxt;
`endif
          if (publish) begin
            delay_q     <= pub_val;
            valid_q     <= 1'b1;
            confirmed_q <= 1'b1;
            match_q     <= '0;
          end else begin
            match_q <= match_nxt;
          end
        end else begin
          match_q <= '0;
          miss_q  <= 1'b1;
        end
      end
    end
  end

  assign hit         = hit_q;
  assign delay_out   = delay_q;
  assign delay_valid = valid_q;
  assign miss        = miss_q;

endmodule

// File: rtl/sos_multi_dist.sv
// Speed-of-sound ranging engine: fires one impulse per round, times the onset
// on every microphone channel and publishes delays once rounds agree.
// Optional build macro SOS_AVG_EN selects averaged publication in the channels.
module sos_multi_dist
  import sos_pkg::*;
#(
  parameter int unsigned N_MICS     = 2,
  parameter int unsigned MAX_DELAY  = 512,
  parameter int unsigned CONFIRM    = 3,
  parameter int unsigned TOL        = 1,
  parameter int unsigned MAX_ROUNDS = 16,
  parameter int unsigned GAP_CYCLES = 98_300_000,
  localparam int unsigned DELAY_W   = $clog2(MAX_DELAY + 1)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        step_in,
  input  logic                        trigger,
  input  logic                        continuous,
  input  logic [14:0]                 thresh,
  input  logic [16*N_MICS-1:0]        mic_in,
  output logic signed [15:0]          amp_out,
  output logic [DELAY_W*N_MICS-1:0]   delay_out,
  output logic [N_MICS-1:0]           delay_valid,
  output logic [N_MICS-1:0]           miss,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned RW = $clog2(MAX_ROUNDS + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  sos_state_t         state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]      rounds_q, rounds_d, rounds_next;
  logic [GW-1:0]      gap_q, gap_d;
  logic               done_q, done_d;

  logic               session_clr, round_clr, listen, eval, impulse_in, impulse_out;
  logic [N_MICS-1:0]  hit, conf_next;

  // Session/round sequencing and counter next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rounds_d    = rounds_q;
    rounds_next = rounds_q;
    gap_d       = gap_q;
    done_d      = 1'b0;
    session_clr = 1'b0;
    round_clr   = 1'b0;
    listen      = 1'b0;
    eval        = 1'b0;
    impulse_in  = 1'b0;
    case (state_q)
      IDLE: begin
        // A trigger landing on the done cycle is dropped.
        if (trigger && !done_q) begin
          session_clr = 1'b1;
          rounds_d    = '0;
          state_d     = FIRE;
        end
      end
      FIRE: begin
        round_clr  = 1'b1;
        impulse_in = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT_IMP;
      end
      WAIT_IMP: begin
        if (impulse_out) begin
          cnt_d   = DELAY_W'(1);
          state_d = LISTEN;
        end
      end
      LISTEN: begin
        if (&hit) begin
          state_d = EVAL;
        end else if (step_in) begin
          listen = 1'b1;
          cnt_d  = cnt_q + DELAY_W'(1);
          if (cnt_q == DELAY_W'(MAX_DELAY)) state_d = EVAL;
        end
      end
      EVAL: begin
        eval = 1'b1;
        // Saturate so a long continuous run cannot wrap past MAX_ROUNDS.
        rounds_next = (rounds_q < RW'(MAX_ROUNDS)) ? (rounds_q + RW'(1)) : rounds_q;
        rounds_d    = rounds_next;
        if (!continuous && ((&conf_next) || (rounds_next >= RW'(MAX_ROUNDS)))) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = FIRE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rounds_q <= '0;
      gap_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rounds_q <= rounds_d;
      gap_q    <= gap_d;
      done_q   <= done_d;
    end
  end

  impulse_generator u_imp (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .step_in     (step_in),
    .impulse_in  (impulse_in),
    .amp_out     (amp_out),
    .impulse_out (impulse_out)
  );

  for (genvar k = 0; k < N_MICS; k++) begin : g_ch
    sos_onset_channel #(
      .MAX_DELAY (MAX_DELAY),
      .CONFIRM   (CONFIRM),
      .TOL       (TOL),
      .DELAY_W   (DELAY_W)
    ) u_ch (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .session_clr (session_clr),
      .round_clr   (round_clr),
      .listen      (listen),
      .eval        (eval),
      .sample      (mic_in[16*k +: 16]),
      .thresh      (thresh),
      .count       (cnt_q),
      .hit         (hit[k]),
      .conf_next   (conf_next[k]),
      .delay_out   (delay_out[DELAY_W*k +: DELAY_W]),
      .delay_valid (delay_valid[k]),
      .miss        (miss[k])
    );
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_sos_multi_dist.sv
// Bench for sos_multi_dist: per-round onset tables drive the microphones and
// a round-level reference model predicts publications, misses and round count.
module tb_sos_multi_dist;

  localparam int N_MICS     = 2;
  localparam int MAX_DELAY  = 512;
  localparam int CONFIRM    = 3;
  localparam int TOL        = 1;
  localparam int MAX_ROUNDS = 16;
  localparam int GAP_CYCLES = 10;
  localparam int DW         = 10;
  localparam int THRESH     = 1000;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic               step_in = 1'b0;
  logic               trigger = 1'b0;
  logic               continuous = 1'b0;
  logic [14:0]        thresh = 15'(THRESH);
  logic [31:0]        mic_in = '0;
  logic signed [15:0] amp_out;
  logic [2*DW-1:0]    delay_out;
  logic [1:0]         delay_valid;
  logic [1:0]         miss;
  logic               busy;
  logic               done;

  always #5 clk_in = ~clk_in;

  sos_multi_dist #(
    .N_MICS     (N_MICS),
    .MAX_DELAY  (MAX_DELAY),
    .CONFIRM    (CONFIRM),
    .TOL        (TOL),
    .MAX_ROUNDS (MAX_ROUNDS),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .step_in     (step_in),
    .trigger     (trigger),
    .continuous  (continuous),
    .thresh      (thresh),
    .mic_in      (mic_in),
    .amp_out     (amp_out),
    .delay_out   (delay_out),
    .delay_valid (delay_valid),
    .miss        (miss),
    .busy        (busy),
    .done        (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-round onset sample index (0 = no onset) and the sample value used.
  int onset[64][2];
  int oval[64][2];

  int rnd_idx;
  int sidx;
  int cont_until;
  bit trig_noise = 1'b1;

  int         pub0[$];
  int         pub1[$];
  int         done_cnt;
  logic [1:0] done_valid;

  int         exp0[$];
  int         exp1[$];
  int         exp_rounds;
  logic [1:0] exp_miss, exp_miss0;
  int         last0 = 0;
  int         last1 = 0;

  // Record every publication and done pulse.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (delay_valid[0]) pub0.push_back(int'(delay_out[DW-1:0]));
      if (delay_valid[1]) pub1.push_back(int'(delay_out[2*DW-1:DW]));
      if (done) begin
        done_cnt++;
        done_valid = delay_valid;
      end
    end
  end

  initial begin
    #(10 * 400000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Round-level reference: agreement runs counted from the onset table.
  task automatic model_session(input int cont_n);
    int mc[2];
    int cand[2];
    int sum[2];
    bit conf[2];
    int o, pv;
    exp0.delete();
    exp1.delete();
    exp_miss   = 2'b00;
    exp_miss0  = 2'b00;
    exp_rounds = 64;
    for (int k = 0; k < 2; k++) begin
      mc[k] = 0; cand[k] = 0; sum[k] = 0; conf[k] = 0;
    end
    for (int r = 0; r < 64; r++) begin
      for (int k = 0; k < 2; k++) begin
        o = onset[r][k];
        if (o >= 1 && o <= MAX_DELAY) begin
          if (mc[k] > 0 && absd(o, cand[k]) <= TOL) begin
            mc[k]++;
            sum[k] += o;
          end else begin
            cand[k] = o;
            mc[k]   = 1;
            sum[k]  = o;
          end
          if (mc[k] == CONFIRM) begin
`ifdef SOS_AVG_EN
            pv = (sum[k] + CONFIRM / 2) / CONFIRM;
`else
            pv = o;
`endif
            if (k == 0) begin exp0.push_back(pv); last0 = pv; end
            else        begin exp1.push_back(pv); last1 = pv; end
            conf[k] = 1;
            mc[k]   = 0;
          end
        end else begin
          mc[k]       = 0;
          exp_miss[k] = 1'b1;
        end
      end
      if (r == 0) exp_miss0 = exp_miss;
      if (!(r < cont_n) && ((conf[0] && conf[1]) || (r + 1 >= MAX_ROUNDS))) begin
        exp_rounds = r + 1;
        break;
      end
    end
  endtask

  function automatic logic [15:0] mic_val(input int k, input int idx);
    int v;
    if (rnd_idx >= 0 && rnd_idx < 64 && onset[rnd_idx][k] == idx) return 16'(oval[rnd_idx][k]);
    case ($urandom_range(0, 7))
      0:       v = THRESH;
      1:       v = -THRESH;
      default: v = int'($urandom_range(0, 2 * THRESH)) - THRESH;
    endcase
    return 16'(v);
  endfunction

  // One audio sample, three clocks long; tracks impulse end to align samples.
  task automatic do_step();
    logic signed [15:0] amp_before;
    @(negedge clk_in);
    amp_before = amp_out;
    step_in    = 1'b1;
    mic_in     = {mic_val(1, sidx + 1), mic_val(0, sidx + 1)};
    trigger    = trig_noise && (rnd_idx inside {[0:1]}) && ($urandom_range(0, 15) == 0);
    @(negedge clk_in);
    step_in = 1'b0;
    trigger = 1'b0;
    sidx++;
    if (amp_before != 0 && amp_out == 0) begin
      rnd_idx++;
      sidx = 0;
      if (rnd_idx == cont_until) continuous = 1'b0;
      if (rnd_idx == 1) check_eq("miss_after_round0", 32'(miss), 32'(exp_miss0));
    end
    @(negedge clk_in);
  endtask

  task automatic start_session(input int cont_n);
    pub0.delete();
    pub1.delete();
    done_cnt   = 0;
    done_valid = 2'b00;
    rnd_idx    = -1;
    sidx       = 0;
    cont_until = cont_n;
    continuous = (cont_n > 0);
    @(negedge clk_in);
    trigger = 1'b1;
    @(negedge clk_in);
    trigger = 1'b0;
    check_eq("busy_after_trigger", 32'(busy), 32'd1);
  endtask

  task automatic run_session(input int cont_n);
    int steps;
    model_session(cont_n);
    start_session(cont_n);
    steps = 0;
    while (busy && steps < 20000) begin
      do_step();
      steps++;
    end
    if (busy) check_eq("session_bounded", 32'(busy), 32'd0);
    @(negedge clk_in);
    check_eq("rounds", 32'(rnd_idx + 1), 32'(exp_rounds));
    check_eq("done_count", 32'(done_cnt), 32'd1);
    check_eq("miss_final", 32'(miss), 32'(exp_miss));
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("pub0_count", 32'(pub0.size()), 32'(exp0.size()));
    check_eq("pub1_count", 32'(pub1.size()), 32'(exp1.size()));
    for (int i = 0; i < exp0.size(); i++)
      check_eq("pub0_value", 32'((i < pub0.size()) ? pub0[i] : -1), 32'(exp0[i]));
    for (int i = 0; i < exp1.size(); i++)
      check_eq("pub1_value", 32'((i < pub1.size()) ? pub1[i] : -1), 32'(exp1[i]));
    check_eq("delay_out0", 32'(delay_out[DW-1:0]), 32'(last0));
    check_eq("delay_out1", 32'(delay_out[2*DW-1:DW]), 32'(last1));
  endtask

  task automatic fill_const(input int o0, input int v0, input int o1, input int v1);
    for (int r = 0; r < 64; r++) begin
      onset[r][0] = o0; oval[r][0] = v0;
      onset[r][1] = o1; oval[r][1] = v1;
    end
  endtask

  function automatic int rand_onset_val();
    int m;
    if ($urandom_range(0, 7) == 0) return -32768;
    m = int'($urandom_range(THRESH + 1, 32767));
    return $urandom_range(0, 1) ? m : -m;
  endfunction

  initial begin
    int guard;
    repeat (3) @(negedge clk_in);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_delay_out", 32'(delay_out), 32'd0);
    check_eq("reset_valid_miss_done", 32'({delay_valid, miss, done}), 32'd0);
    check_eq("reset_amp", 32'(amp_out), 32'd0);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);

    // Stable echo: both channels confirm together on round 3.
    fill_const(40, 5000, 73, -6000);
    run_session(0);
    check_eq("stable_valid_with_done", 32'(done_valid), 32'd3);
    check_eq("stable_delay_out", 32'(delay_out), 32'({10'd73, 10'd40}));

    // Jitter within tolerance.
    fill_const(40, 3000, 73, 3000);
    onset[1][0] = 41;
    run_session(0);

    // Match restart: 40, 43, 43, 43.
    fill_const(43, 2500, 10, -2500);
    onset[0][0] = 40;
    run_session(0);

    // Saturating negative onset at sample 5.
    fill_const(5, -32768, 5, 32767);
    run_session(0);

    // Continuous mode for six rounds, then a normal finish.
    fill_const(20, 4000, 30, -4000);
    run_session(6);

    // Timeout on channel 1 for the whole session.
    fill_const(40, 5000, 0, 0);
    run_session(0);

    // Abort mid-LISTEN with reset, then restart cleanly.
    fill_const(40, 5000, 73, 5000);
    start_session(0);
    guard = 0;
    while (!(rnd_idx == 0 && sidx == 20) && guard < 2000) begin
      do_step();
      guard++;
    end
    check_eq("abort_reached_listen", 32'(rnd_idx), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_delay_out", 32'(delay_out), 32'd0);
    check_eq("abort_flags", 32'({delay_valid, miss, done}), 32'd0);
    check_eq("abort_amp", 32'(amp_out), 32'd0);
    rst_in = 1'b0;
    last0 = 0;
    last1 = 0;
    @(negedge clk_in);
    run_session(0);

    // Randomized onsets with jitter around a per-session base.
    for (int s = 0; s < 4; s++) begin
      int b0, b1;
      b0 = int'($urandom_range(3, 120));
      b1 = int'($urandom_range(3, 120));
      for (int r = 0; r < 64; r++) begin
        onset[r][0] = b0 + int'($urandom_range(0, 4)) - 2;
        onset[r][1] = b1 + int'($urandom_range(0, 4)) - 2;
        oval[r][0]  = rand_onset_val();
        oval[r][1]  = rand_onset_val();
      end
      run_session(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
